// File: rtl/decimal_to_bcd_encoder.sv
// Registered one-hot decimal (10 lines) to BCD encoder with valid and
// multi-hot error flags; PRIORITY selects the multi-hot policy.
module decimal_to_bcd_encoder #(
    parameter int PRIORITY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] d,
    output logic       D,
    output logic       C,
    output logic       B,
    output logic       A,
    output logic       valid,
    output logic       err
);

    logic [3:0] enc;
    logic [3:0] hot_cnt;
    logic       multi_hot;
    logic       none_hot;

    logic [3:0] code_d,  code_q;
    logic       valid_d, valid_q;
    logic       err_d,   err_q;

    // Later (higher) indices overwrite earlier ones, so enc ends on the highest set line.
    always_comb begin
        enc     = '0;
        hot_cnt = '0;
        for (int k = 0; k < 10; k++) begin
            if (d[k]) begin
                enc     = 4'(k);
                hot_cnt = hot_cnt + 4'd1;
            end
        end
    end

    assign multi_hot = (hot_cnt > 4'd1);
    assign none_hot  = (hot_cnt == 4'd0);

    always_comb begin
        code_d  = enc;
        valid_d = !none_hot;
        err_d   = multi_hot;
        if (multi_hot && (PRIORITY == 0)) begin
            code_d  = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            code_q  <= code_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign D     = code_q[3];
    assign C     = code_q[2];
    assign B     = code_q[1];
    assign A     = code_q[0];
    assign valid = valid_q;
    assign err   = err_q;

endmodule

// File: tb/tb_decimal_to_bcd_encoder.sv
// Directed bench for decimal_to_bcd_encoder; both multi-hot policies are
// instantiated side by side and checked as {D,C,B,A,valid,err}.
module tb_decimal_to_bcd_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] d;

    logic p_D, p_C, p_B, p_A, p_valid, p_err;
    logic n_D, n_C, n_B, n_A, n_valid, n_err;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    decimal_to_bcd_encoder #(.PRIORITY(1)) u_pri (
        .clk(clk), .rst_n(rst_n), .d(d),
        .D(p_D), .C(p_C), .B(p_B), .A(p_A), .valid(p_valid), .err(p_err)
    );

    decimal_to_bcd_encoder #(.PRIORITY(0)) u_npri (
        .clk(clk), .rst_n(rst_n), .d(d),
        .D(n_D), .C(n_C), .B(n_B), .A(n_A), .valid(n_valid), .err(n_err)
    );

    // Drive d on the falling edge, then sample just after the next rising edge.
    task automatic step(input logic [9:0] v);
        @(negedge clk);
        d = v;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [5:0] exp_p, input logic [5:0] exp_n);
        logic [5:0] obs_p;
        logic [5:0] obs_n;
        obs_p = {p_D, p_C, p_B, p_A, p_valid, p_err};
        obs_n = {n_D, n_C, n_B, n_A, n_valid, n_err};
        n_assert++;
        assert (obs_p === exp_p) else begin
            n_fail++;
            $error("FAIL %s pri1 observed=%b expected=%b", tag, obs_p, exp_p);
        end
        n_assert++;
        assert (obs_n === exp_n) else begin
            n_fail++;
            $error("FAIL %s pri0 observed=%b expected=%b", tag, obs_n, exp_n);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        d     = 10'b0000100000;
        #1;
        check("reset_immediate", 6'b0000_0_0, 6'b0000_0_0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", 6'b0000_0_0, 6'b0000_0_0);

        @(negedge clk);
        rst_n = 1'b1;
        step(10'b0000100000);
        check("after_release_d5", 6'b0101_1_0, 6'b0101_1_0);

        for (int k = 0; k < 10; k++) begin
            logic [3:0] kc;
            kc = 4'(k);
            step(10'(1) << k);
            check($sformatf("walk_%0d", k), {kc, 2'b10}, {kc, 2'b10});
        end

        step(10'b0000000000);
        check("zero_input", 6'b0000_0_0, 6'b0000_0_0);
        step(10'b0000000001);
        check("digit0_valid", 6'b0000_1_0, 6'b0000_1_0);

        step(10'b1000001000);
        check("multi_3_9", 6'b1001_1_1, 6'b0000_0_1);
        step(10'b0010001000);
        check("multi_3_7", 6'b0111_1_1, 6'b0000_0_1);
        step(10'b1111111111);
        check("multi_all", 6'b1001_1_1, 6'b0000_0_1);
        step(10'b0000000011);
        check("multi_0_1", 6'b0001_1_1, 6'b0000_0_1);

        step(10'b0010000000);
        check("pre_mid_reset", 6'b0111_1_0, 6'b0111_1_0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset_clear", 6'b0000_0_0, 6'b0000_0_0);
        @(negedge clk);
        rst_n = 1'b1;
        step(10'b0010000000);
        check("post_mid_reset", 6'b0111_1_0, 6'b0111_1_0);

        for (int i = 0; i < 5; i++) begin
            step(10'b0100000000);
            check($sformatf("hold_%0d", i), 6'b1000_1_0, 6'b1000_1_0);
        end
        #3;
        check("hold_between_edges", 6'b1000_1_0, 6'b1000_1_0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/decimal_to_bcd_encoder.md
Name: decimal_to_bcd_encoder

Overview:
- Registered 10-line decimal (one-hot) to 4-bit BCD encoder.
- Input line d[k] active high means decimal digit k. Outputs {D,C,B,A} carry the BCD code of k, with D as MSB.
- Adds a valid flag and an error flag for zero-hot and multi-hot inputs.
- Used as the front-end encoder for keypad or selector inputs that feed BCD arithmetic and display logic.

Parameters:
- PRIORITY, default 1. Multi-hot policy:
  - 1: the highest set index is encoded.
  - 0: the code is forced to 0000 and valid is deasserted.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- d  input  10  decimal lines; d[k] is digit k, active high.
- D  output  1  BCD bit 3 (MSB, weight 8), registered.
- C  output  1  BCD bit 2 (weight 4), registered.
- B  output  1  BCD bit 1 (weight 2), registered.
- A  output  1  BCD bit 0 (LSB, weight 1), registered.
- valid  output  1  registered; 1 when {D,C,B,A} holds a legitimate digit code.
- err  output  1  registered; 1 when the sampled d was multi-hot.

Behaviour:
- Reset:
  - While rst_n = 0, D = C = B = A = 0, valid = 0 and err = 0, regardless of clk.
  - Assertion takes effect immediately; no clock edge is needed.
  - After rst_n rises, the first rising clk edge samples d normally.
- Latency:
  - d is sampled on each rising clk edge. Outputs reflect that sample after the same edge, a one-cycle latency.
  - There is no combinational path from d to any output.
  - Outputs hold their values between edges.
- Exactly one bit d[k] set, k = 0..9:
  - {D,C,B,A} = k in binary. Example: d[0] gives 0000, d[5] gives 0101, d[9] gives 1001.
  - valid = 1, err = 0.
  - d[0] alone is a valid zero: code 0000 with valid = 1.
- d == 0 (no line active): {D,C,B,A} = 0000, valid = 0, err = 0.
- More than one bit set, err = 1 in both policies:
  - PRIORITY = 1: encode the highest set index, valid = 1. Example: d[3] and d[7] give 0111.
  - PRIORITY = 0: {D,C,B,A} = 0000, valid = 0.
- Code range: the output code never exceeds 1001. Codes 1010 to 1111 are unreachable.
- Persistence: a held input produces the same registered outputs every cycle. There is no edge detection and no stickiness.
- Asynchronous reset mid-stream: outputs clear at once. Pre-reset samples are discarded; nothing is buffered.
- Unknown values (X) on d are outside scope. The encoder need not produce defined outputs for them.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with d = 10'b0000100000 → D,C,B,A = 0000, valid = 0, err = 0 throughout. After release, the first edge gives 0101, valid = 1.
- Walking one: drive d = 1<<k for k = 0..9, 1 cycle each → one cycle later {D,C,B,A} = k (0000, 0001, 0010, ..., 1000, 1001), valid = 1, err = 0 each cycle.
- Zero input: d = 0 → code 0000, valid = 0, err = 0. Contrast with d = 10'b0000000001, which gives 0000 with valid = 1.
- Multi-hot, PRIORITY = 1: d = 10'b1000001000 → 1001, valid = 1, err = 1. With PRIORITY = 0, the same d gives 0000, valid = 0, err = 1.
- Reset mid-operation: with d = 10'b0010000000 and output 0111, pulse rst_n low between clock edges → outputs clear immediately to 0000/0/0. They return to 0111 on the first edge after release.
- Hold stability: keep d = 10'b0100000000 for 5 cycles → the output stays 1000, valid = 1, err = 0, with no glitches.
